reg2axil: RTL and testbench

REG2AXIL -- requirements
Module: reg2axil

---
 rtl/reg2axil.sv | 205 ++++++++++++++++++++
 tb/tb_reg2axil.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg2axil.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg2axil                                                         |
// | Purpose : Bridges a simple valid/ready register request port onto an       |
// |           AXI4-Lite master. One transaction is in flight at a time, and    |
// |           each one ends with a single-cycle rsp_valid completion pulse.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module reg2axil #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request / response port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI-Lite read address
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // AXI-Lite read data
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  // AXI-Lite write address
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // AXI-Lite write data
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // AXI-Lite write response
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AW_W = 3'd1;
  localparam logic [2:0] S_WR_B    = 3'd2;
  localparam logic [2:0] S_RD_AR   = 3'd3;
  localparam logic [2:0] S_RD_R    = 3'd4;

  logic [2:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                  req_ready_q, req_ready_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  bready_q,    bready_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  rready_q,    rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q,  rsp_resp_d;

  // AW and W finish independently; a channel counts as done once its valid has dropped
  // or its handshake lands this cycle.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !awvalid_q || m_axil_awready;
  assign w_w_done  = !wvalid_q  || m_axil_wready;

  // Next-state and next-output computation; every AXI handshake signal is produced as a
  // registered _d value so nothing on the master side is combinational from AXI inputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end
      S_WR_AW_W: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (w_aw_done && w_w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (m_axil_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axil_bresp;
          state_d     = S_IDLE;
        end
      end
      S_RD_AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (m_axil_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
          state_d     = S_IDLE;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    // Ready is registered so it is low during reset and rises on the first edge after it.
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_reg2axil.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_reg2axil                                                      |
// | Purpose : Self-checking bench for reg2axil: directed vector table, reset   |
// |           sequence and randomized transactions against a timing model.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_reg2axil;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arprot, awprot;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;

  reg2axil #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [31:0] rdata;   // slave read data
    logic [1:0]  resp;    // slave bresp / rresp
    logic [7:0]  e_lat;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // reference model state: what the response port should hold after each completion
  logic [31:0] m_rdata;
  logic [1:0]  m_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, input int aw, input int w, input int b,
                              input int ar, input int r, input logic [31:0] rd,
                              input logic [1:0] rs, input int e_lat,
                              input logic [31:0] e_rd, input logic [1:0] e_rs);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = st;
    v.aw_dly = 8'(aw); v.w_dly = 8'(w); v.b_dly = 8'(b); v.ar_dly = 8'(ar); v.r_dly = 8'(r);
    v.rdata = rd; v.resp = rs; v.e_lat = 8'(e_lat); v.e_rdata = e_rd; v.e_resp = e_rs;
    return v;
  endfunction

  // Zero-wait completion is 3 cycles; every slave wait state adds one cycle, and the
  // write path waits for the slower of its AW and W channels.
  function automatic int model_lat(input vec_t v);
    int mx;
    mx = (v.aw_dly > v.w_dly) ? int'(v.aw_dly) : int'(v.w_dly);
    return v.we ? 3 + mx + int'(v.b_dly) : 3 + int'(v.ar_dly) + int'(v.r_dly);
  endfunction

  function automatic void model_apply(input vec_t v);
    if (!v.we) m_rdata = v.rdata;
    m_resp = v.resp;
  endfunction

  // Issues one request starting at a negedge with the DUT idle, plays the slave and checks
  // the per-cycle handshake pattern. Returns at the negedge where rsp_valid is seen.
  task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd,
                         output logic [1:0] rs);
    int aw, w, b, ar, r, mx, el;
    logic e_aw, e_w, e_b, e_ar, e_r, e_rsp;
    aw = int'(v.aw_dly); w = int'(v.w_dly); b = int'(v.b_dly);
    ar = int'(v.ar_dly); r = int'(v.r_dly);
    mx = (aw > w) ? aw : w;
    el = model_lat(v);
    lat = -1; rd = '0; rs = '0;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    for (int c = 1; c <= el + 20; c++) begin
      @(negedge clk);
      // keep the request port busy with junk; it must be ignored outside IDLE
      req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      e_aw  = v.we && (c <= 1 + aw);
      e_w   = v.we && (c <= 1 + w);
      e_b   = v.we && (c >= 2 + mx) && (c <= 2 + mx + b);
      e_ar  = !v.we && (c <= 1 + ar);
      e_r   = !v.we && (c >= 2 + ar) && (c <= 2 + ar + r);
      e_rsp = (c == el);
      chk("ctl{aw,w,b,ar,r,rsp,rdy}",
          {57'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready},
          {57'd0, e_aw, e_w, e_b, e_ar, e_r, e_rsp, e_rsp});
      if (awvalid) chk("awaddr", {32'd0, awaddr}, {32'd0, v.addr});
      if (wvalid)  chk("wdata_wstrb", {28'd0, wstrb, wdata}, {28'd0, v.wstrb, v.wdata});
      if (arvalid) chk("araddr", {32'd0, araddr}, {32'd0, v.addr});
      if (c == 1)  chk("prot", {58'd0, awprot, arprot}, 64'd0);
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; rs = rsp_resp;
        break;
      end
      awready = v.we && (c == 1 + aw);
      wready  = v.we && (c == 1 + w);
      bvalid  = v.we && (c == 2 + mx + b);
      bresp   = (v.we && c == 2 + mx + b) ? v.resp : 2'($urandom);
      arready = !v.we && (c == 1 + ar);
      if (v.we) begin
        rvalid = 1'($urandom);   // stray read beats must be ignored during a write
        rdata  = $urandom;
        rresp  = 2'($urandom);
      end else begin
        rvalid = (c == 2 + ar + r);
        rdata  = (c == 2 + ar + r) ? v.rdata : $urandom;
        rresp  = (c == 2 + ar + r) ? v.resp : 2'($urandom);
        bvalid = 1'($urandom);   // stray write responses must be ignored during a read
      end
    end
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  vec_t tbl [6];
  vec_t v;
  int lat;
  logic [31:0] rd;
  logic [1:0]  rs;

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0; awready = 0; wready = 0;
    bresp = 0; bvalid = 0;
    m_rdata = '0; m_resp = '0;

    //            we  addr          wdata         strb aw w b ar r  slave rdata   rsp  lat exp rdata    exp rsp
    tbl[0] = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0,        2'b00, 3, 32'h0,        2'b00);
    tbl[1] = mk(0, 32'h0000_1000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEF0, 2'b00, 3, 32'hDEAD_BEF0, 2'b00);
    tbl[2] = mk(1, 32'h0000_1004, 32'h0102_0304, 4'hF, 4, 0, 0, 0, 0, 32'h0,        2'b00, 7, 32'hDEAD_BEF0, 2'b00);
    tbl[3] = mk(0, 32'h0000_2000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hBAD0_2000, 2'b10, 3, 32'hBAD0_2000, 2'b10);
    tbl[4] = mk(1, 32'h0000_2004, 32'h1234_5678, 4'h3, 0, 2, 1, 0, 0, 32'h0,        2'b01, 6, 32'hBAD0_2000, 2'b01);
    tbl[5] = mk(0, 32'h0000_3008, 32'h0,         4'h0, 0, 0, 0, 2, 3, 32'hCAFE_F00D, 2'b11, 8, 32'hCAFE_F00D, 2'b11);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {56'd0, req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, 1'b0}, 64'd0);
    chk("reset_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], lat, rd, rs);
      model_apply(tbl[i]);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].e_lat));
      chk($sformatf("tbl%0d_rdata", i), {32'd0, rd}, {32'd0, tbl[i].e_rdata});
      chk($sformatf("tbl%0d_resp", i), {62'd0, rs}, {62'd0, tbl[i].e_resp});
    end
    req_valid = 0;

    // reset asserted while waiting in WR_B
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h0000_4000; req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 0; awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    chk("rst_pre_bready", {63'd0, bready}, 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_ctl", {57'd0, req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 64'd0);
    chk("rst_async_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
    bvalid = 1; bresp = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_hold", {62'd0, rsp_valid, bready}, 64'd0);
    bvalid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst_release", {62'd0, req_ready, rsp_valid}, 64'd2);
    m_rdata = '0; m_resp = '0;
    v = mk(0, 32'h0000_1000, 32'h0, 4'h0, 1, 0, 0, 1, 0, 32'h7777_0001, 2'b00, 4, 32'h7777_0001, 2'b00);
    run_txn(v, lat, rd, rs);
    model_apply(v);
    chk("post_rst_lat", 64'(lat), 64'(v.e_lat));
    chk("post_rst_rdata", {32'd0, rd}, {32'd0, m_rdata});

    // randomized back-to-back transactions against the model
    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom, 2'($urandom), 0, 32'h0, 2'b00);
      run_txn(v, lat, rd, rs);
      model_apply(v);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(model_lat(v)));
      chk($sformatf("rnd%0d_rsp", i), {30'd0, rs, rd}, {30'd0, m_resp, m_rdata});
    end
    req_valid = 0;
    @(negedge clk);
    chk("final_idle", {62'd0, req_ready, rsp_valid}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
